fft_window_axis: RTL and testbench



---
 rtl/fft_window_axis_if.sv | 14 +
 rtl/fft_window_axis.sv | 150 +++++++++++++++
 tb/tb_fft_window_axis.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_window_axis_if.sv
// AXI-Stream bundle for the FFT window block: complex sample, in-frame index, handshake, frame end.
interface fft_window_axis_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LOG2_N = 5
);
    logic [2*DATA_W-1:0] tdata;
    logic [LOG2_N-1:0]   tuser;
    logic                tvalid;
    logic                tready;
    logic                tlast;

    modport master (output tdata, output tuser, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/fft_window_axis.sv
// Streaming complex-by-real window multiplier with runtime-loadable coefficients,
// in-frame index regeneration, bypass, backpressure and frame-length error flags.
module fft_window_axis #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned COEF_W  = 18,
    parameter int unsigned LOG2_N  = 5,
    parameter int unsigned LATENCY = 4
) (
    input  logic                aclk,
    input  logic                aresetn,
    fft_window_axis_if.slave    s_axis,
    fft_window_axis_if.master   m_axis,
    input  logic                bypass,
    input  logic                coef_wr_en,
    input  logic [LOG2_N-1:0]   coef_wr_addr,
    input  logic [COEF_W-1:0]   coef_wr_data,
    output logic                err_tlast_unexpected,
    output logic                err_tlast_missing
);
    localparam int unsigned N    = 2**LOG2_N;
    localparam int unsigned P_W  = DATA_W + COEF_W + 1;
    localparam int unsigned SH_W = P_W - COEF_W + 1;

    localparam logic [LOG2_N-1:0]     IDX_LAST = '1;
    localparam logic signed [COEF_W:0] COEF_ONE = {2'b01, {(COEF_W-1){1'b0}}};
    localparam logic signed [P_W-1:0]  RND      = {{(P_W-COEF_W+1){1'b0}}, 1'b1, {(COEF_W-2){1'b0}}};
    localparam logic signed [SH_W-1:0] SAT_MAX  = {{(SH_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [SH_W-1:0] SAT_MIN  = {{(SH_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    // Coefficient storage: no reset, read-before-write on address collision.
    logic [COEF_W-1:0] coef_ram [N];

    logic                     ready_en;
    logic [LOG2_N-1:0]        idx;
    logic [LATENCY-1:0]       vld;

    logic signed [DATA_W-1:0] s1_re, s1_im;
    logic                     s1_byp, s1_last;
    logic [LOG2_N-1:0]        s1_user;
    logic [COEF_W-1:0]        coef_q;

    logic signed [DATA_W-1:0] s2_re, s2_im;
    logic signed [COEF_W:0]   s2_coef;
    logic                     s2_last;
    logic [LOG2_N-1:0]        s2_user;

    logic signed [P_W-1:0]    s3_p_re, s3_p_im;
    logic                     s3_last;
    logic [LOG2_N-1:0]        s3_user;

    logic signed [DATA_W-1:0] out_re, out_im;
    logic                     out_last;
    logic [LOG2_N-1:0]        out_user;

    logic                     stall_c, accept_c, idx_last_c;
    logic signed [P_W-1:0]    rnd_re_c, rnd_im_c;
    logic signed [SH_W-1:0]   sh_re_c, sh_im_c;

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [SH_W-1:0] x);
        if (x > SAT_MAX)      sat = {1'b0, {(DATA_W-1){1'b1}}};
        else if (x < SAT_MIN) sat = {1'b1, {(DATA_W-1){1'b0}}};
        else                  sat = DATA_W'(x);
    endfunction

    // Whole pipeline freezes only while the output holds an unaccepted beat.
    assign stall_c        = vld[LATENCY-1] && !m_axis.tready;
    assign s_axis.tready  = ready_en && !stall_c;
    assign accept_c       = s_axis.tvalid && ready_en && !stall_c;
    assign idx_last_c     = (idx == IDX_LAST);

    assign rnd_re_c = s3_p_re + RND;
    assign rnd_im_c = s3_p_im + RND;
    assign sh_re_c  = SH_W'(rnd_re_c >>> (COEF_W-1));
    assign sh_im_c  = SH_W'(rnd_im_c >>> (COEF_W-1));

    assign m_axis.tdata  = {out_im, out_re};
    assign m_axis.tuser  = out_user;
    assign m_axis.tlast  = out_last;
    assign m_axis.tvalid = vld[LATENCY-1];

    always_ff @(posedge aclk) begin
        if (coef_wr_en) coef_ram[coef_wr_addr] <= coef_wr_data;
    end

    // Frame index and length checking; error flags are not gated by the stall.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ready_en             <= 1'b0;
            idx                  <= '0;
            err_tlast_unexpected <= 1'b0;
            err_tlast_missing    <= 1'b0;
        end else begin
            ready_en             <= 1'b1;
            err_tlast_unexpected <= accept_c && s_axis.tlast && !idx_last_c;
            err_tlast_missing    <= accept_c && !s_axis.tlast && idx_last_c;
            if (accept_c) idx <= (s_axis.tlast || idx_last_c) ? '0 : idx + LOG2_N'(1);
        end
    end

    // Four-stage datapath: capture/RAM read, coefficient select, multiply, round/saturate.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            vld      <= '0;
            s1_re    <= '0;
            s1_im    <= '0;
            s1_byp   <= 1'b0;
            s1_last  <= 1'b0;
            s1_user  <= '0;
            coef_q   <= '0;
            s2_re    <= '0;
            s2_im    <= '0;
            s2_coef  <= '0;
            s2_last  <= 1'b0;
            s2_user  <= '0;
            s3_p_re  <= '0;
            s3_p_im  <= '0;
            s3_last  <= 1'b0;
            s3_user  <= '0;
            out_re   <= '0;
            out_im   <= '0;
            out_last <= 1'b0;
            out_user <= '0;
        end else if (!stall_c) begin
            vld      <= {vld[LATENCY-2:0], accept_c};

            s1_re    <= s_axis.tdata[DATA_W-1:0];
            s1_im    <= s_axis.tdata[2*DATA_W-1:DATA_W];
            s1_byp   <= bypass;
            s1_last  <= idx_last_c || s_axis.tlast;
            s1_user  <= idx;
            coef_q   <= coef_ram[idx];

            s2_re    <= s1_re;
            s2_im    <= s1_im;
            s2_coef  <= s1_byp ? COEF_ONE : {1'b0, coef_q};
            s2_last  <= s1_last;
            s2_user  <= s1_user;

            s3_p_re  <= P_W'(s2_re) * P_W'(s2_coef);
            s3_p_im  <= P_W'(s2_im) * P_W'(s2_coef);
            s3_last  <= s2_last;
            s3_user  <= s2_user;

            out_re   <= sat(sh_re_c);
            out_im   <= sat(sh_im_c);
            out_last <= s3_last;
            out_user <= s3_user;
        end
    end
endmodule

// File: tb/tb_fft_window_axis.sv
// Directed + randomized bench for fft_window_axis against an integer-arithmetic frame model.
module tb_fft_window_axis;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 18;
    localparam int unsigned LN = 5;
    localparam int          N  = 32;
    localparam longint      MAXV = 32767;
    localparam longint      MINV = -32768;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          bypass = 1'b0;
    logic          coef_wr_en = 1'b0;
    logic [LN-1:0] coef_wr_addr = '0;
    logic [CW-1:0] coef_wr_data = '0;
    logic          err_u, err_m;

    int checks = 0;
    int errors = 0;

    fft_window_axis_if #(.DATA_W(DW), .LOG2_N(LN)) s_if ();
    fft_window_axis_if #(.DATA_W(DW), .LOG2_N(LN)) m_if ();

    fft_window_axis #(.DATA_W(DW), .COEF_W(CW), .LOG2_N(LN), .LATENCY(4)) dut (
        .aclk                 (clk),
        .aresetn              (rst_n),
        .s_axis               (s_if),
        .m_axis               (m_if),
        .bypass               (bypass),
        .coef_wr_en           (coef_wr_en),
        .coef_wr_addr         (coef_wr_addr),
        .coef_wr_data         (coef_wr_data),
        .err_tlast_unexpected (err_u),
        .err_tlast_missing    (err_m)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*DW-1:0] data;
        logic [LN-1:0]   user;
        logic            last;
        int              t;
        bit              seen;
    } exp_t;

    exp_t exp_q[$];
    int   mram [N];
    int   m_idx = 0;
    bit   pend_u = 1'b0, pend_m = 1'b0;
    int   ncyc = 0;
    bit   lat_chk = 1'b0;
    bit   bp_on = 1'b0;
    int   bp_i = 0;
    bit   pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: real-valued window with half-up rounding and clamping to the data range.
    function automatic int wmul(input int x, input int c, input bit byp);
        longint p;
        if (byp) return x;
        p = (longint'(x) * longint'(c) + (longint'(1) << (CW-2))) >>> (CW-1);
        if (p > MAXV) p = MAXV;
        if (p < MINV) p = MINV;
        return int'(p);
    endfunction

    function automatic int rnd16();
        return int'($urandom_range(65535)) - 32768;
    endfunction

    // Monitor: models frame indexing, coefficient RAM, error pulses and output order.
    always @(negedge clk) begin : mon
        logic signed [DW-1:0] re_s, im_s;
        int   c;
        exp_t e;
        ncyc++;
        if (!rst_n) begin
            check("rst_tvalid", 64'(m_if.tvalid), 64'(0));
            check("rst_tdata", 64'(m_if.tdata), 64'(0));
            check("rst_tuser", 64'(m_if.tuser), 64'(0));
            check("rst_tlast", 64'(m_if.tlast), 64'(0));
            check("rst_err_u", 64'(err_u), 64'(0));
            check("rst_err_m", 64'(err_m), 64'(0));
            check("rst_s_tready", 64'(s_if.tready), 64'(0));
            exp_q.delete();
            m_idx  = 0;
            pend_u = 1'b0;
            pend_m = 1'b0;
        end else begin
            check("err_unexpected", 64'(err_u), 64'(pend_u));
            check("err_missing", 64'(err_m), 64'(pend_m));
            if (m_if.tvalid) begin
                check("beat_pending", 64'(exp_q.size() > 0), 64'(1));
                if (exp_q.size() > 0) begin
                    check("tdata", 64'(m_if.tdata), 64'(exp_q[0].data));
                    check("tuser", 64'(m_if.tuser), 64'(exp_q[0].user));
                    check("tlast", 64'(m_if.tlast), 64'(exp_q[0].last));
                    if (!exp_q[0].seen) begin
                        if (lat_chk) check("latency", 64'(ncyc - exp_q[0].t), 64'(4));
                        exp_q[0].seen = 1'b1;
                    end
                    if (m_if.tready) void'(exp_q.pop_front());
                end
            end
            pend_u = 1'b0;
            pend_m = 1'b0;
            if (s_if.tvalid && s_if.tready) begin
                re_s   = s_if.tdata[DW-1:0];
                im_s   = s_if.tdata[2*DW-1:DW];
                c      = mram[m_idx];
                e.data = {DW'(wmul(int'(im_s), c, bypass)), DW'(wmul(int'(re_s), c, bypass))};
                e.user = LN'(m_idx);
                e.last = (m_idx == N-1) || s_if.tlast;
                e.t    = ncyc;
                e.seen = 1'b0;
                exp_q.push_back(e);
                pend_u = s_if.tlast && (m_idx != N-1);
                pend_m = !s_if.tlast && (m_idx == N-1);
                m_idx  = (s_if.tlast || m_idx == N-1) ? 0 : m_idx + 1;
            end
            if (coef_wr_en) mram[coef_wr_addr] = int'(coef_wr_data);
        end
    end

    task automatic tick_ready();
        if (bp_on) begin
            m_if.tready = pat[bp_i % 5];
            bp_i++;
        end else begin
            m_if.tready = 1'b1;
        end
    endtask

    task automatic send_beat(input int re, input int im, input bit last, input bit byp,
                             input bit wr, input int wa, input int wd);
        int n = 0;
        bit acc = 1'b0;
        s_if.tdata   = {DW'(im), DW'(re)};
        s_if.tlast   = last;
        s_if.tvalid  = 1'b1;
        bypass       = byp;
        coef_wr_en   = wr;
        coef_wr_addr = LN'(wa);
        coef_wr_data = CW'(wd);
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = s_if.tready;
            @(posedge clk);
            #1;
            coef_wr_en = 1'b0;
            tick_ready();
            n++;
        end
        check("beat_accepted", 64'(acc), 64'(1));
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic beat(input int re, input int im, input bit last, input bit byp);
        send_beat(re, im, last, byp, 1'b0, 0, 0);
    endtask

    task automatic load_coef(input int a, input int d);
        coef_wr_en   = 1'b1;
        coef_wr_addr = LN'(a);
        coef_wr_data = CW'(d);
        @(posedge clk);
        #1;
        coef_wr_en = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || m_if.tvalid) && n < 500) begin
            @(posedge clk);
            #1;
            tick_ready();
            n++;
        end
        check("drained", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = '0;
        m_if.tready = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("tready_after_reset", 64'(s_if.tready), 64'(1));

        // Bypass impulse, then a random bypass frame.
        lat_chk = 1'b1;
        for (int i = 0; i < N; i++) beat((i == 2) ? 32000 : 0, 0, i == N-1, 1'b1);
        for (int i = 0; i < N; i++) beat(rnd16(), rnd16(), i == N-1, 1'b1);
        drain();

        // Half scale with rounding corner cases.
        for (int i = 0; i < N; i++) load_coef(i, 'h10000);
        beat(32000, -32000, 1'b0, 1'b0);
        beat(3, -3, 1'b0, 1'b0);
        beat(-3, 3, 1'b0, 1'b0);
        for (int i = 3; i < N; i++) beat(rnd16(), rnd16(), i == N-1, 1'b0);
        drain();

        // Near-2.0 gain to exercise saturation.
        for (int i = 0; i < N; i++) load_coef(i, 'h3FFFF);
        beat(32767, -32768, 1'b0, 1'b0);
        beat(-32768, 32767, 1'b0, 1'b0);
        beat(100, -100, 1'b0, 1'b0);
        for (int i = 3; i < N; i++) beat(rnd16(), rnd16(), i == N-1, 1'b0);
        drain();

        // Random coefficients, random per-beat bypass, output backpressure pattern.
        for (int i = 0; i < N; i++) load_coef(i, int'($urandom_range(262143)));
        lat_chk = 1'b0;
        bp_on   = 1'b1;
        for (int i = 0; i < 3*N; i++)
            beat(rnd16(), rnd16(), (i % N) == N-1, ($urandom_range(3) == 0));
        bp_on = 1'b0;
        drain();
        lat_chk = 1'b1;

        // Early tlast at idx 9, then a frame missing tlast at idx 31 that wraps.
        for (int i = 0; i < 10; i++) beat(rnd16(), rnd16(), i == 9, 1'b0);
        for (int i = 0; i < 2*N; i++) beat(rnd16(), rnd16(), i == 2*N-1, 1'b0);
        drain();

        // Reset in mid-frame; coefficients survive.
        for (int i = 0; i < 17; i++) beat(rnd16(), rnd16(), 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("tready_after_midreset", 64'(s_if.tready), 64'(1));
        for (int i = 0; i < N; i++) beat(rnd16(), rnd16(), i == N-1, 1'b0);

        // Coefficient write colliding with the read of idx 5.
        for (int i = 0; i < N; i++)
            send_beat(rnd16(), rnd16(), i == N-1, 1'b0, i == 5, 5, (mram[5] + 'h9000) % 262144);
        for (int i = 0; i < N; i++) beat(rnd16(), rnd16(), i == N-1, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
